ask4_pwm_demod: RTL

ASK4_PWM_DEMOD -- requirements
Module: ask4_pwm_demod

---
 rtl/ask4_pkg.sv | 19 +
 rtl/ask4_duty_meter.sv | 54 +++++
 rtl/ask4_pwm_demod.sv | 114 +++++++++++
 3 files changed

// File: rtl/ask4_pkg.sv
// Shared types, constants and the slicer threshold helper for the 4-ASK PWM demodulator.
package ask4_pkg;

    typedef logic [1:0] dibit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIBITS = 4;

    // Decision threshold at quarter/4 of a symbol period, truncated to an integer.
    function automatic int unsigned threshold(input int unsigned sym_cycles,
                                              input int unsigned quarter);
        return (quarter * sym_cycles) / 4;
    endfunction

endpackage

// File: rtl/ask4_duty_meter.sv
// Synchronizes the PWM line and frame enable, and measures high time per symbol window.
module ask4_duty_meter #(
    parameter int SYM_CYCLES = 62500
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pwm_in,
    input  logic                                allow,
    output logic                                allow_sync,
    output logic                                win_close,
    output logic [$clog2(SYM_CYCLES + 1)-1:0]   high_total,
    output logic                                cnt_active
);

    localparam int CNT_W = $clog2(SYM_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_CYCLES - 1);

    logic             pwm_meta;
    logic             pwm_sync;
    logic             allow_meta;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] high_cnt;

    // allow goes through the same two stages as pwm_in so each window lines up with its samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_meta   <= 1'b0;
            pwm_sync   <= 1'b0;
            allow_meta <= 1'b0;
            allow_sync <= 1'b0;
            sym_cnt    <= '0;
            high_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so each stage captures the previous stage's pre-edge value.
            pwm_meta   <= pwm_in;
            pwm_sync   <= pwm_meta;
            allow_meta <= allow;
            allow_sync <= allow_meta;
            if (!allow_sync || win_close) begin
                sym_cnt  <= '0;
                high_cnt <= '0;
            end else begin
                sym_cnt  <= sym_cnt + CNT_W'(1);
                high_cnt <= high_total;
            end
        end
    end

    // The closing sample is folded in combinationally so the decision sees all SYM_CYCLES samples.
    assign win_close  = allow_sync && (sym_cnt == LAST);
    assign high_total = high_cnt + CNT_W'(pwm_sync);
    assign cnt_active = (sym_cnt != '0);

endmodule

// File: rtl/ask4_pwm_demod.sv
// 4-ASK PWM demodulator: slices each symbol's duty cycle into a dibit and packs four per byte.
module ask4_pwm_demod
    import ask4_pkg::dibit_t, ask4_pkg::state_t, ask4_pkg::IDLE, ask4_pkg::RUN, ask4_pkg::threshold;
#(
    parameter int SYM_CYCLES = 62500,
    parameter int DIBITS     = ask4_pkg::DIBITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       allow,
    output logic [1:0] dibit_out,
    output logic       sym_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy
);

    localparam int CNT_W = $clog2(SYM_CYCLES + 1);
    localparam int IDX_W = $clog2(DIBITS);

    localparam logic [CNT_W-1:0] T1 = CNT_W'(threshold(SYM_CYCLES, 1));
    localparam logic [CNT_W-1:0] T2 = CNT_W'(threshold(SYM_CYCLES, 2));
    localparam logic [CNT_W-1:0] T3 = CNT_W'(threshold(SYM_CYCLES, 3));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIBITS - 1);

    logic             allow_sync;
    logic             win_close;
    logic [CNT_W-1:0] high_total;
    logic             cnt_active;

    state_t           state;
    state_t           state_next;
    dibit_t           dibit_next;
    logic [IDX_W-1:0] idx;
    logic [7:0]       byte_sr;

    ask4_duty_meter #(
        .SYM_CYCLES (SYM_CYCLES)
    ) u_meter (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .allow      (allow),
        .allow_sync (allow_sync),
        .win_close  (win_close),
        .high_total (high_total),
        .cnt_active (cnt_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through this block can leave state_next unassigned and infer a latch.
        state_next = state;
        unique case (state)
            IDLE: if (allow_sync)  state_next = RUN;
            RUN:  if (!allow_sync) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) && ((idx != '0) || cnt_active);
    end

    // Equality with a threshold lands in the upper bucket.
    always_comb begin
        if (high_total < T1) begin
            dibit_next = 2'b00;
        end else if (high_total < T2) begin
            dibit_next = 2'b01;
        end else if (high_total < T3) begin
            dibit_next = 2'b10;
        end else begin
            dibit_next = 2'b11;
        end
    end

    // A gap in allow throws away any partial byte; data_out keeps the last complete one.
    always_ff @(posedge clk) begin
        if (rst) begin
            dibit_out  <= '0;
            sym_valid  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            byte_sr    <= '0;
            idx        <= '0;
        end else begin
            sym_valid  <= win_close;
            data_valid <= 1'b0;
            if (!allow_sync) begin
                idx <= '0;
            end else if (win_close) begin
                dibit_out <= dibit_next;
                byte_sr   <= {byte_sr[5:0], dibit_next};
                if (idx == LAST_IDX) begin
                    data_out   <= {byte_sr[5:0], dibit_next};
                    data_valid <= 1'b1;
                    idx        <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule
